// File: rtl/m2_fetch_sprime_pkg.sv
`default_nettype none
// ============================================================================
// m2_fetch_sprime_pkg : shared M2 state types, project constants, helpers
// Revision 1.0
// ============================================================================
package m2_fetch_sprime_pkg;

    typedef enum logic [1:0] {
        S_M2_IDLE,
        S_M2_FETCH,
        S_M2_COMPUTE,
        S_M2_WRITE
    } M2_state_type;

    typedef enum logic [1:0] {
        S_FETCH_IDLE,
        S_FETCH_ISSUE,
        S_FETCH_DRAIN,
        S_FETCH_DONE
    } M2_fetch_state_type;

    localparam logic [17:0] DEFAULT_BASE_ADDR    = 18'd76800;
    localparam int          DEFAULT_IMG_WIDTH    = 320;
    localparam int          DEFAULT_SRAM_LATENCY = 3;

    function automatic logic [31:0] sign_extend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/m2_fetch_sprime_if.sv
`default_nettype none
// ============================================================================
// m2_fetch_sprime_if : start/SRAM/DPRAM signal bundle of the S' fetch unit
// Revision 1.0
// ============================================================================
interface m2_fetch_sprime_if;
    logic        START_I;
    logic [4:0]  BLOCK_ROW_I;
    logic [5:0]  BLOCK_COL_I;
    logic [17:0] SRAM_ADDRESS_O;
    logic        SRAM_WE_N_O;
    logic [15:0] SRAM_READ_DATA_I;
    logic [6:0]  DPRAM_ADDRESS_O;
    logic [31:0] DPRAM_WRITE_DATA_O;
    logic        DPRAM_WE_O;
    logic        BUSY_O;
    logic        DONE_O;

    modport slave (
        input  START_I, BLOCK_ROW_I, BLOCK_COL_I, SRAM_READ_DATA_I,
        output SRAM_ADDRESS_O, SRAM_WE_N_O, DPRAM_ADDRESS_O,
               DPRAM_WRITE_DATA_O, DPRAM_WE_O, BUSY_O, DONE_O
    );

    modport master (
        output START_I, BLOCK_ROW_I, BLOCK_COL_I, SRAM_READ_DATA_I,
        input  SRAM_ADDRESS_O, SRAM_WE_N_O, DPRAM_ADDRESS_O,
               DPRAM_WRITE_DATA_O, DPRAM_WE_O, BUSY_O, DONE_O
    );
endinterface
`default_nettype wire

// File: rtl/m2_fetch_sprime_valid_delay.sv
`default_nettype none
// ============================================================================
// m2_valid_delay : DEPTH-stage shift register carrying a valid flag + index
// Revision 1.0
// ============================================================================
module m2_valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic       CLOCK_I,
    input  logic       RESETN_I,
    input  logic       valid,
    input  logic [5:0] index,
    output logic       delayed_valid,
    output logic [5:0] delayed_index
);
    logic [DEPTH-1:0] valid_pipe;
    logic [5:0]       index_pipe [DEPTH];

    always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            valid_pipe[0] <= 1'b0;
            index_pipe[0] <= 6'd0;
        end else begin
            valid_pipe[0] <= valid;
            index_pipe[0] <= index;
        end
    end

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_stage
            always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
                if (!RESETN_I) begin
                    valid_pipe[i] <= 1'b0;
                    index_pipe[i] <= 6'd0;
                end else begin
                    valid_pipe[i] <= valid_pipe[i-1];
                    index_pipe[i] <= index_pipe[i-1];
                end
            end
        end
    endgenerate

    assign delayed_valid = valid_pipe[DEPTH-1];
    assign delayed_index = index_pipe[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/m2_fetch_sprime.sv
`default_nettype none
// ============================================================================
// m2_fetch_sprime : reads one 8x8 S' block from SRAM into DPRAM0 port B
// Revision 1.0
// ============================================================================
module m2_fetch_sprime
    import m2_fetch_sprime_pkg::*;
#(
    parameter logic [17:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int          IMG_WIDTH    = DEFAULT_IMG_WIDTH,
    parameter int          SRAM_LATENCY = DEFAULT_SRAM_LATENCY
) (
    input  logic             CLOCK_I,
    input  logic             RESETN_I,
    m2_fetch_sprime_if.slave bus
);
    localparam logic [17:0] ROW_STRIDE = 18'(IMG_WIDTH);

    M2_fetch_state_type state;
    logic [2:0]  elem_row;
    logic [2:0]  elem_col;
    logic [17:0] row_base;
    logic [17:0] sram_address;
    logic [17:0] start_address;
    logic        busy;
    logic        done;

    logic        issue_valid;
    logic [5:0]  issue_index;
    logic        delayed_valid;
    logic [5:0]  delayed_index;

    logic        dpram_we;
    logic [5:0]  dpram_index;
    logic [31:0] dpram_data;

    // The only multiply is the block-origin offset, taken once per START.
    assign start_address = 18'(32'(BASE_ADDR)
                             + 32'(bus.BLOCK_ROW_I) * 32'(8 * IMG_WIDTH)
                             + 32'(bus.BLOCK_COL_I) * 32'd8);

    assign issue_valid = (state == S_FETCH_ISSUE);
    assign issue_index = {elem_row, elem_col};

    always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            state        <= S_FETCH_IDLE;
            elem_row     <= 3'd0;
            elem_col     <= 3'd0;
            row_base     <= 18'd0;
            sram_address <= 18'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_FETCH_IDLE: begin
                    if (bus.START_I) begin
                        state        <= S_FETCH_ISSUE;
                        elem_row     <= 3'd0;
                        elem_col     <= 3'd0;
                        row_base     <= start_address;
                        sram_address <= start_address;
                        busy         <= 1'b1;
                    end
                end
                S_FETCH_ISSUE: begin
                    if (elem_col == 3'd7) begin
                        elem_col <= 3'd0;
                        if (elem_row == 3'd7) begin
                            state <= S_FETCH_DRAIN;
                        end else begin
                            elem_row     <= elem_row + 3'd1;
                            row_base     <= row_base + ROW_STRIDE;
                            sram_address <= row_base + ROW_STRIDE;
                        end
                    end else begin
                        elem_col     <= elem_col + 3'd1;
                        sram_address <= sram_address + 18'd1;
                    end
                end
                S_FETCH_DRAIN: begin
                    // Leave once the last element is on the write port.
                    if (dpram_we && dpram_index == 6'd63) begin
                        state <= S_FETCH_DONE;
                        done  <= 1'b1;
                    end
                end
                S_FETCH_DONE: begin
                    state <= S_FETCH_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_FETCH_IDLE;
            endcase
        end
    end

    m2_valid_delay #(
        .DEPTH(SRAM_LATENCY)
    ) u_valid_delay (
        .CLOCK_I       (CLOCK_I),
        .RESETN_I      (RESETN_I),
        .valid         (issue_valid),
        .index         (issue_index),
        .delayed_valid (delayed_valid),
        .delayed_index (delayed_index)
    );

    always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            dpram_we    <= 1'b0;
            dpram_index <= 6'd0;
            dpram_data  <= 32'd0;
        end else begin
            dpram_we <= delayed_valid;
            if (delayed_valid) begin
                dpram_index <= delayed_index;
                dpram_data  <= sign_extend16(bus.SRAM_READ_DATA_I);
            end
        end
    end

    assign bus.SRAM_ADDRESS_O     = sram_address;
    assign bus.SRAM_WE_N_O        = 1'b1;
    assign bus.DPRAM_ADDRESS_O    = {1'b0, dpram_index};
    assign bus.DPRAM_WRITE_DATA_O = dpram_data;
    assign bus.DPRAM_WE_O         = dpram_we;
    assign bus.BUSY_O             = busy;
    assign bus.DONE_O             = done;
endmodule
`default_nettype wire

// File: tb/tb_m2_fetch_sprime.sv
`default_nettype none
// ============================================================================
// tb_m2_fetch_sprime : three latency variants driven in lockstep vs a model
// Revision 1.0
// ============================================================================
module tb_m2_fetch_sprime;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  brow = 5'd0;
    logic [5:0]  bcol = 6'd0;
    int          mode = 0;
    logic [15:0] seed = 16'd0;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m2_fetch_sprime_if bus1 ();
    m2_fetch_sprime_if bus3 ();
    m2_fetch_sprime_if bus4 ();

    m2_fetch_sprime #(.SRAM_LATENCY(1)) u_dut1 (.CLOCK_I(clk), .RESETN_I(rstn), .bus(bus1));
    m2_fetch_sprime #(.SRAM_LATENCY(3)) u_dut3 (.CLOCK_I(clk), .RESETN_I(rstn), .bus(bus3));
    m2_fetch_sprime #(.SRAM_LATENCY(4)) u_dut4 (.CLOCK_I(clk), .RESETN_I(rstn), .bus(bus4));

    // SRAM content as a function of address
    function automatic logic [15:0] mem(input logic [17:0] a, input int md, input logic [15:0] sd);
        case (md)
            0:       return a[15:0];
            1:       return a[15:0] ^ sd;
            default: return a[0] ? 16'h8001 : 16'h7FFF;
        endcase
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [17:0] exp_addr(input int row, input int col, input int e);
        return 18'(76800 + (row * 8 + e / 8) * 320 + col * 8 + e % 8);
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    // SRAM models: address history, data appears LAT cycles after address
    logic [17:0] h1 [4];
    logic [17:0] h3 [4];
    logic [17:0] h4 [4];
    always @(posedge clk) begin
        h1[0] <= bus1.SRAM_ADDRESS_O;
        h3[0] <= bus3.SRAM_ADDRESS_O;
        h4[0] <= bus4.SRAM_ADDRESS_O;
        for (int i = 1; i < 4; i++) begin
            h1[i] <= h1[i-1];
            h3[i] <= h3[i-1];
            h4[i] <= h4[i-1];
        end
    end
    assign bus1.SRAM_READ_DATA_I = mem(h1[0], mode, seed);
    assign bus3.SRAM_READ_DATA_I = mem(h3[2], mode, seed);
    assign bus4.SRAM_READ_DATA_I = mem(h4[3], mode, seed);

    assign bus1.START_I = start;  assign bus1.BLOCK_ROW_I = brow;  assign bus1.BLOCK_COL_I = bcol;
    assign bus3.START_I = start;  assign bus3.BLOCK_ROW_I = brow;  assign bus3.BLOCK_COL_I = bcol;
    assign bus4.START_I = start;  assign bus4.BLOCK_ROW_I = brow;  assign bus4.BLOCK_COL_I = bcol;

    logic [31:0] cap [3][64];
    int          wr_cnt [3];
    int          done_cnt [3];
    logic [17:0] first_sa [3];
    logic [17:0] last_sa [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic sample(input int d, output logic [17:0] sa, output logic wen, output logic we,
                          output logic [6:0] da, output logic [31:0] dd, output logic busy,
                          output logic done);
        case (d)
            0: begin sa = bus1.SRAM_ADDRESS_O; wen = bus1.SRAM_WE_N_O; we = bus1.DPRAM_WE_O;
                     da = bus1.DPRAM_ADDRESS_O; dd = bus1.DPRAM_WRITE_DATA_O;
                     busy = bus1.BUSY_O; done = bus1.DONE_O; end
            1: begin sa = bus3.SRAM_ADDRESS_O; wen = bus3.SRAM_WE_N_O; we = bus3.DPRAM_WE_O;
                     da = bus3.DPRAM_ADDRESS_O; dd = bus3.DPRAM_WRITE_DATA_O;
                     busy = bus3.BUSY_O; done = bus3.DONE_O; end
            default: begin sa = bus4.SRAM_ADDRESS_O; wen = bus4.SRAM_WE_N_O; we = bus4.DPRAM_WE_O;
                     da = bus4.DPRAM_ADDRESS_O; dd = bus4.DPRAM_WRITE_DATA_O;
                     busy = bus4.BUSY_O; done = bus4.DONE_O; end
        endcase
    endtask

    task automatic check_reset_state(input string tag);
        logic [17:0] sa; logic wen, we, busy, done; logic [6:0] da; logic [31:0] dd;
        for (int d = 0; d < 3; d++) begin
            sample(d, sa, wen, we, da, dd, busy, done);
            chk($sformatf("%s L%0d sram_addr", tag, lat(d)), 32'(sa), 32'd0);
            chk($sformatf("%s L%0d we_n", tag, lat(d)), 32'(wen), 32'd1);
            chk($sformatf("%s L%0d dpram_we", tag, lat(d)), 32'(we), 32'd0);
            chk($sformatf("%s L%0d dpram_addr", tag, lat(d)), 32'(da), 32'd0);
            chk($sformatf("%s L%0d dpram_data", tag, lat(d)), dd, 32'd0);
            chk($sformatf("%s L%0d busy", tag, lat(d)), 32'(busy), 32'd0);
            chk($sformatf("%s L%0d done", tag, lat(d)), 32'(done), 32'd0);
        end
    endtask

    // One block request; extra start pulses at xs1/xs2, optional reset at rst_at
    task automatic run_block(input int row, input int col, input int md, input logic [15:0] sd,
                             input int xs1, input int xs2, input int rst_at);
        logic [17:0] sa; logic wen, we, busy, done; logic [6:0] da; logic [31:0] dd;
        int L, e;
        bit ab, ebusy, edone, ewe;
        mode = md;
        seed = sd;
        for (int d = 0; d < 3; d++) begin
            wr_cnt[d] = 0;
            done_cnt[d] = 0;
            for (int i = 0; i < 64; i++) cap[d][i] = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        brow = 5'(row);
        bcol = 6'(col);
        start = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            @(posedge clk); #1;
            start = (t == xs1 || t == xs2);
            brow = 5'($urandom_range(0, 29));
            bcol = 6'($urandom_range(0, 39));
            if (rst_at > 0 && t == rst_at) rstn = 1'b0;
            if (rst_at > 0 && t == rst_at + 2) rstn = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                sample(d, sa, wen, we, da, dd, busy, done);
                L = lat(d);
                ab = (rst_at > 0 && t >= rst_at);
                ebusy = !ab && t <= 66 + L;
                edone = !ab && t == 66 + L;
                ewe = !ab && t >= 2 + L && t <= 65 + L;
                chk($sformatf("t%0d L%0d busy", t, L), 32'(busy), 32'(ebusy));
                chk($sformatf("t%0d L%0d done", t, L), 32'(done), 32'(edone));
                chk($sformatf("t%0d L%0d dpram_we", t, L), 32'(we), 32'(ewe));
                chk($sformatf("t%0d L%0d we_n", t, L), 32'(wen), 32'd1);
                if (!ab && t <= 64)
                    chk($sformatf("t%0d L%0d sram_addr", t, L), 32'(sa), 32'(exp_addr(row, col, t - 1)));
                if (ewe) begin
                    e = t - 2 - L;
                    chk($sformatf("t%0d L%0d dpram_addr", t, L), 32'(da), 32'(e));
                    chk($sformatf("t%0d L%0d dpram_data", t, L), dd,
                        sext(mem(exp_addr(row, col, e), md, sd)));
                end
                if (ab && t < rst_at + 2) begin
                    chk($sformatf("t%0d L%0d rst sram_addr", t, L), 32'(sa), 32'd0);
                    chk($sformatf("t%0d L%0d rst dpram_data", t, L), dd, 32'd0);
                end
                if (we === 1'b1) begin
                    wr_cnt[d]++;
                    cap[d][da[5:0]] = dd;
                end
                if (done === 1'b1) done_cnt[d]++;
                if (t == 1) first_sa[d] = sa;
                if (t == 64) last_sa[d] = sa;
            end
        end
        for (int d = 0; d < 3; d++) begin
            L = lat(d);
            chk($sformatf("L%0d write count", L), 32'(wr_cnt[d]), (rst_at > 0) ? 32'(28 - L) : 32'd64);
            chk($sformatf("L%0d done count", L), 32'(done_cnt[d]), (rst_at > 0) ? 32'd0 : 32'd1);
        end
        rstn = 1'b1;
    endtask

    typedef struct {
        int          row;
        int          col;
        int          md;
        logic [17:0] first;
        logic [17:0] last;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d8;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{0,  0,  0, 18'd76800,  18'd79047,  32'h0000_2C00, 32'h0000_2C01, 32'h0000_2D40};
        vecs[1] = '{29, 39, 0, 18'd151352, 18'd153599, 32'h0000_4F38, 32'h0000_4F39, 32'h0000_5078};
        vecs[2] = '{0,  0,  2, 18'd76800,  18'd79047,  32'h0000_7FFF, 32'hFFFF_8001, 32'h0000_7FFF};
        vecs[3] = '{3,  5,  0, 18'd84520,  18'd86767,  32'h0000_4A28, 32'h0000_4A29, 32'h0000_4B68};

        rstn = 1'b0;
        #1;
        check_reset_state("async reset");
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].row, vecs[v].col, vecs[v].md, 16'd0, 0, 0, 0);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("vec%0d L%0d first addr", v, lat(d)), 32'(first_sa[d]), 32'(vecs[v].first));
                chk($sformatf("vec%0d L%0d last addr", v, lat(d)), 32'(last_sa[d]), 32'(vecs[v].last));
                chk($sformatf("vec%0d L%0d dpram[0]", v, lat(d)), cap[d][0], vecs[v].d0);
                chk($sformatf("vec%0d L%0d dpram[1]", v, lat(d)), cap[d][1], vecs[v].d1);
                chk($sformatf("vec%0d L%0d dpram[8]", v, lat(d)), cap[d][8], vecs[v].d8);
            end
        end

        // Restarts while busy (incl. the DONE cycle of the latency-1 unit) are ignored
        run_block(2, 7, 0, 16'd0, 10, 67, 0);

        // Abort mid-fetch, then a normal block after release
        run_block(4, 9, 0, 16'd0, 0, 0, 30);
        run_block(5, 11, 1, 16'h5A5A, 0, 0, 0);

        for (int n = 0; n < 6; n++) begin
            run_block(int'($urandom_range(0, 29)), int'($urandom_range(0, 39)), 1,
                      16'($urandom), 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
